// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the ALU operation scheduler.
package alu_sched_pkg;

   localparam logic [2:0] OP_XNOR = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_RRA  = 3'd3;
   localparam logic [2:0] OP_RLA  = 3'd4;
   localparam logic [2:0] OP_RRB  = 3'd5;
   localparam logic [2:0] OP_RLB  = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   localparam logic [1:0] ROT_BY1 = 2'b00;
   localparam logic [1:0] ROT_BY2 = 2'b01;
   localparam logic [1:0] ROT_BY3 = 2'b10;
   localparam logic [1:0] ROT_BY0 = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic is_rsvd(input logic [2:0] op);
      return op == OP_RSVD;
   endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves only when a grant is accepted.
module rr_arb2
   import alu_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   // ptr_q = 1 means req1 is favoured when both request
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr_q ? 2'b10 : 2'b01;
      end
   end

   assign ptr_d = accept ? gnt[0] : ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Arbitrates two requesters onto the shared 4-bit ALU and returns tagged, registered results.
//   state | meaning
//   IDLE  | waiting for a request; only the arbiter winner sees ready
//   EXEC  | ALU settling on the registered operands
//   RESP  | response held until rsp_ready
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [1:0]       req0_rot,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [1:0]       req1_rot,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_s,
   output logic [1:0]       alu_s_rotate,
   input  logic [3:0]       alu_y,
   input  logic             alu_y2,
   input  logic             alu_cout,
   input  logic             alu_bout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [3:0]       rsp_y,
   output logic             rsp_y2,
   output logic             rsp_cout,
   output logic             rsp_bout,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   state_t     state_q, state_d;
   logic [1:0] gnt_w;
   logic       idle_w;
   logic       accept_w;
   logic       id_q;
   logic [3:0] alu_a_q, alu_b_q, rsp_y_q;
   logic [2:0] alu_s_q;
   logic [1:0] alu_rot_q;
   logic       rsp_id_q, rsp_y2_q, rsp_cout_q, rsp_bout_q, rsp_err_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({req1_valid, req0_valid}),
      .accept (accept_w),
      .gnt    (gnt_w)
   );

   // ready is masked during reset so nothing is accepted on the reset edge
   assign idle_w     = (state_q == IDLE) && !rst;
   assign req0_ready = idle_w && gnt_w[0];
   assign req1_ready = idle_w && gnt_w[1];
   assign accept_w   = req0_ready || req1_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_w) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         id_q       <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_s_q    <= '0;
         alu_rot_q  <= '0;
         rsp_id_q   <= 1'b0;
         rsp_y_q    <= '0;
         rsp_y2_q   <= 1'b0;
         rsp_cout_q <= 1'b0;
         rsp_bout_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         cnt0_q     <= '0;
         cnt1_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept_w) begin
            id_q      <= gnt_w[1];
            alu_a_q   <= gnt_w[1] ? req1_a   : req0_a;
            alu_b_q   <= gnt_w[1] ? req1_b   : req0_b;
            alu_s_q   <= gnt_w[1] ? req1_op  : req0_op;
            alu_rot_q <= gnt_w[1] ? req1_rot : req0_rot;
         end
         if (state_q == EXEC) begin
            rsp_id_q   <= id_q;
            rsp_y_q    <= alu_y;
            rsp_y2_q   <= alu_y2;
            rsp_cout_q <= alu_cout;
            rsp_bout_q <= alu_bout;
            rsp_err_q  <= is_rsvd(alu_s_q);
         end
         if (state_q == RESP && rsp_ready) begin
            if (rsp_id_q) cnt1_q <= cnt1_q + 1'b1;
            else          cnt0_q <= cnt0_q + 1'b1;
         end
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_s        = alu_s_q;
   assign alu_s_rotate = alu_rot_q;
   assign rsp_valid    = (state_q == RESP);
   assign busy         = (state_q != IDLE);
   assign rsp_id       = rsp_id_q;
   assign rsp_y        = rsp_y_q;
   assign rsp_y2       = rsp_y2_q;
   assign rsp_cout     = rsp_cout_q;
   assign rsp_bout     = rsp_bout_q;
   assign rsp_err      = rsp_err_q;
   assign done_cnt0    = cnt0_q;
   assign done_cnt1    = cnt1_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: stands in for the ALU and checks against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_op_scheduler;

   localparam int CNT_W = 8;

   typedef struct packed {
      logic [3:0] y;
      logic       y2;
      logic       cout;
      logic       bout;
   } alu_res_t;

   typedef struct packed {
      logic       id;
      logic [3:0] y;
      logic       y2;
      logic       cout;
      logic       bout;
      logic       err;
   } rsp_t;

   typedef struct packed {
      logic [2:0] s;
      logic [1:0] rot;
      logic [3:0] a;
      logic [3:0] b;
   } opnd_t;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [2:0] req0_op, req1_op;
   logic [1:0] req0_rot, req1_rot;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] alu_a, alu_b, alu_y;
   logic [2:0] alu_s;
   logic [1:0] alu_s_rotate;
   logic alu_y2, alu_cout, alu_bout;
   logic rsp_valid, rsp_ready, rsp_id, rsp_y2, rsp_cout, rsp_bout, rsp_err, busy;
   logic [3:0] rsp_y;
   logic [CNT_W-1:0] done_cnt0, done_cnt1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_op_scheduler #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_rot(req0_rot), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_rot(req1_rot), .req1_a(req1_a), .req1_b(req1_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_s_rotate(alu_s_rotate),
      .alu_y(alu_y), .alu_y2(alu_y2), .alu_cout(alu_cout), .alu_bout(alu_bout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .rsp_y2(rsp_y2), .rsp_cout(rsp_cout), .rsp_bout(rsp_bout), .rsp_err(rsp_err),
      .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
   );

   // behavioural stand-in for four_bit_alu; Y2 is taken as "Y nonzero"
   function automatic alu_res_t alu_fn(input logic [2:0] s, input logic [1:0] r,
                                       input logic [3:0] a, input logic [3:0] b);
      alu_res_t   res;
      logic [4:0] t;
      logic [7:0] da, db;
      int         n, nl;
      res = '0;
      n   = (r == 2'b11) ? 0 : int'(r) + 1;
      nl  = (4 - n) % 4;
      da  = {a, a};
      db  = {b, b};
      case (s)
         3'd0: res.y = ~(a ^ b);
         3'd1: begin t = {1'b0, a} + {1'b0, b}; res.y = t[3:0]; res.cout = t[4]; end
         3'd2: begin t = {1'b0, a} - {1'b0, b}; res.y = t[3:0]; res.bout = t[4]; end
         3'd3: res.y = da[n +: 4];
         3'd4: res.y = da[nl +: 4];
         3'd5: res.y = db[n +: 4];
         3'd6: res.y = db[nl +: 4];
         default: res.y = 4'd0;
      endcase
      res.y2 = |res.y;
      return res;
   endfunction

   alu_res_t alu_w;
   assign alu_w    = alu_fn(alu_s, alu_s_rotate, alu_a, alu_b);
   assign alu_y    = alu_w.y;
   assign alu_y2   = alu_w.y2;
   assign alu_cout = alu_w.cout;
   assign alu_bout = alu_w.bout;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // model: one transaction in flight, response visible two cycles after acceptance
   logic       m_in_flight;
   int         m_age;
   logic       m_fav;
   logic [7:0] m_cnt0, m_cnt1;
   rsp_t       m_rsp, m_pend;
   opnd_t      m_alu;

   initial begin : compare
      logic     exp_r0, exp_r1, ridx;
      alu_res_t ar;
      m_in_flight = 1'b0; m_age = 0; m_fav = 1'b0;
      m_cnt0 = '0; m_cnt1 = '0; m_rsp = '0; m_pend = '0; m_alu = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("ready0_in_reset", int'(req0_ready), 0);
            chk("ready1_in_reset", int'(req1_ready), 0);
            m_in_flight = 1'b0; m_age = 0; m_fav = 1'b0;
            m_cnt0 = '0; m_cnt1 = '0; m_rsp = '0; m_alu = '0;
         end else begin
            if (m_in_flight) begin
               m_age++;
               if (m_age == 2) m_rsp = m_pend;
            end
            exp_r0 = 1'b0;
            exp_r1 = 1'b0;
            if (!m_in_flight) begin
               if (req0_valid && req1_valid) begin
                  exp_r0 = !m_fav;
                  exp_r1 = m_fav;
               end else begin
                  exp_r0 = req0_valid;
                  exp_r1 = req1_valid;
               end
            end
            chk("ready0", int'(req0_ready), int'(exp_r0));
            chk("ready1", int'(req1_ready), int'(exp_r1));
            chk("busy", int'(busy), int'(m_in_flight));
            chk("rsp_valid", int'(rsp_valid), int'(m_in_flight && m_age >= 2));
            chk("rsp_fields", int'({rsp_id, rsp_y, rsp_y2, rsp_cout, rsp_bout, rsp_err}), int'(m_rsp));
            chk("alu_outputs", int'({alu_s, alu_s_rotate, alu_a, alu_b}), int'(m_alu));
            chk("done_cnt0", int'(done_cnt0), int'(m_cnt0));
            chk("done_cnt1", int'(done_cnt1), int'(m_cnt1));
            if (m_in_flight && m_age >= 2 && rsp_ready) begin
               if (m_rsp.id) m_cnt1 = m_cnt1 + 8'd1;
               else          m_cnt0 = m_cnt0 + 8'd1;
               m_in_flight = 1'b0;
            end
            if (exp_r0 || exp_r1) begin
               ridx  = exp_r1;
               m_fav = exp_r0;
               m_alu = ridx ? {req1_op, req1_rot, req1_a, req1_b} : {req0_op, req0_rot, req0_a, req0_b};
               ar    = alu_fn(m_alu.s, m_alu.rot, m_alu.a, m_alu.b);
               m_pend = {ridx, ar.y, ar.y2, ar.cout, ar.bout, m_alu.s == 3'd7};
               m_in_flight = 1'b1;
               m_age = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic id, input logic [2:0] op, input logic [1:0] rot,
                       input logic [3:0] a, input logic [3:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_rot = rot; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_rot = rot; req0_a = a; req0_b = b;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((id && req1_ready) || (!id && req0_ready)) begin
            tick();
            if (id) req1_valid = 1'b0;
            else    req0_valid = 1'b0;
            return;
         end
      end
      timeout("send_accept");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rsp_valid) return;
      end
      timeout("wait_rsp");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      timeout("wait_idle");
   endtask

   // called at a negedge with both valids high; records the grant order
   task automatic run_pair(output logic first, output logic second);
      int   n;
      logic ord [2];
      n = 0;
      ord[0] = 1'b0;
      ord[1] = 1'b0;
      for (int i = 0; i < 40 && n < 2; i++) begin
         if (req0_ready) begin
            ord[n] = 1'b0; n++; tick(); req0_valid = 1'b0;
         end else if (req1_ready) begin
            ord[n] = 1'b1; n++; tick(); req1_valid = 1'b0;
         end
         if (n < 2) @(negedge clk);
      end
      if (n < 2) timeout("run_pair");
      first  = ord[0];
      second = ord[1];
   endtask

   initial begin : stimulus
      int   n;
      logic g0, g1;
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_rot = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_rot = '0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_alu_a", int'(alu_a), 0);
      chk("reset_done_cnt0", int'(done_cnt0), 0);
      tick();

      // add, then reset while its response is held
      rsp_ready = 1'b0;
      send(1'b0, 3'b001, 2'b00, 4'b1100, 4'b0011);
      wait_rsp(n);
      chk("add_latency", n, 2);
      chk("add_rsp_y", int'(rsp_y), 'hf);
      chk("add_rsp_y2", int'(rsp_y2), 1);
      chk("add_rsp_cout", int'(rsp_cout), 0);
      chk("add_rsp_id", int'(rsp_id), 0);
      tick();
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'b000; req0_rot = 2'b00; req0_a = 4'b1010; req0_b = 4'b1010;
      req1_valid = 1'b1; req1_op = 3'b000; req1_rot = 2'b00; req1_a = 4'b0101; req1_b = 4'b0000;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstresp_rsp_valid", int'(rsp_valid), 0);
      chk("rstresp_busy", int'(busy), 0);
      chk("rstresp_done_cnt0", int'(done_cnt0), 0);
      chk("rstresp_ready0", int'(req0_ready), 1);
      chk("rstresp_ready1", int'(req1_ready), 0);

      // contention: two pairs, req0 first each time
      run_pair(g0, g1);
      chk("pair1_first", int'(g0), 0);
      chk("pair1_second", int'(g1), 1);
      wait_idle();
      tick();
      req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0110;
      req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b0001;
      @(negedge clk);
      run_pair(g0, g1);
      chk("pair2_first", int'(g0), 0);
      chk("pair2_second", int'(g1), 1);
      wait_idle();
      tick();

      send(1'b0, 3'b001, 2'b00, 4'b1100, 4'b0011);
      wait_rsp(n);
      chk("add2_latency", n, 2);
      chk("add2_rsp_y", int'(rsp_y), 'hf);
      wait_idle();
      chk("add2_done_cnt0", int'(done_cnt0), 3);
      tick();

      // backpressure with req1 waiting
      rsp_ready = 1'b0;
      send(1'b0, 3'b011, 2'b00, 4'b1100, 4'b0000);
      req1_valid = 1'b1; req1_op = 3'b010; req1_rot = 2'b00; req1_a = 4'b0011; req1_b = 4'b1100;
      wait_rsp(n);
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_y", int'(rsp_y), 'h6);
         chk("bp_rsp_valid", int'(rsp_valid), 1);
         chk("bp_ready1", int'(req1_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      n = 0;
      for (int i = 1; i < 20 && n == 0; i++) begin
         @(negedge clk);
         if (req1_ready) n = i;
      end
      chk("bp_next_accept_delay", n, 2);
      tick();
      req1_valid = 1'b0;
      wait_rsp(n);
      chk("sub_rsp_y", int'(rsp_y), 'h7);
      chk("sub_rsp_bout", int'(rsp_bout), 1);
      chk("sub_rsp_y2", int'(rsp_y2), 1);
      chk("sub_rsp_id", int'(rsp_id), 1);
      wait_idle();
      tick();

      send(1'b0, 3'b111, 2'b00, 4'b1111, 4'b1111);
      wait_rsp(n);
      chk("rsvd_rsp_y", int'(rsp_y), 0);
      chk("rsvd_rsp_err", int'(rsp_err), 1);
      wait_idle();
      tick();

      // counter wrap on req1 from a clean reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 255; i++) begin
         send(1'b1, 3'(i % 7), 2'(i % 4), 4'(i), 4'(i >> 4));
      end
      wait_idle();
      chk("wrap_done_cnt1_255", int'(done_cnt1), 255);
      tick();
      send(1'b1, 3'b001, 2'b00, 4'b0001, 4'b0001);
      wait_idle();
      chk("wrap_done_cnt1_0", int'(done_cnt1), 0);
      chk("wrap_done_cnt0", int'(done_cnt0), 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Sequencer and two-port arbiter for the shared combinational 4-bit ALU (`four_bit_alu`). Two requesters submit operations (opcode, rotate select, A, B) over valid/ready handshakes. A round-robin arbiter grants one request at a time. The block drives registered operands into the ALU, captures Y, Y2, COUT and BOUT after one execute cycle, and returns a tagged response over a valid/ready handshake. It sits between the ALU and its clients.

## Interface
Parameters:
- CNT_W, 8, width of per-requester completion counters

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  3  ALU select S
- req0_rot / req1_rot  in  2  ALU S_rotate
- req0_a, req0_b / req1_a, req1_b  in  4  operands
- alu_a, alu_b  out  4  operands to ALU
- alu_s  out  3  ALU select
- alu_s_rotate  out  2  ALU rotate select
- alu_y  in  4  ALU result
- alu_y2, alu_cout, alu_bout  in  1  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester tag (0/1)
- rsp_y  out  4  captured Y
- rsp_y2, rsp_cout, rsp_bout  out  1  captured flags
- rsp_err  out  1  opcode was 3'b111 (reserved; result forced 0 by ALU)
- busy  out  1  state != IDLE
- done_cnt0, done_cnt1  out  CNT_W  completed responses per requester

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - reqN_ready = 1 only for the arbiter winner. Ready is combinational from state, the valids and the priority pointer.
  - On valid&ready, capture op, rot, a and b into the alu_* registers and the tag into id_q, then go to EXEC.
  - With no valid request, stay in IDLE.
- Arbitration:
  - A lone valid request wins.
  - If both are valid, the requester not granted last wins.
  - The pointer updates only on acceptance. After reset it favours req0.
- EXEC: lasts exactly one cycle. The ALU settles from the registered alu_* outputs. At the cycle end, capture alu_y, alu_y2, alu_cout, alu_bout, the id and err=(op==3'b111) into the rsp_* registers, then go to RESP.
- RESP:
  - rsp_valid = 1, and all rsp_* outputs are held stable until rsp_valid&rsp_ready.
  - On that handshake, increment done_cnt[rsp_id] and return to IDLE.
  - Both reqN_ready are 0 in EXEC and RESP.
- Counters wrap modulo 2^CNT_W (255 -> 0 at the default width).
- alu_* outputs keep their last values outside EXEC; they are not cleared.
- Reserved opcode 111: executed normally (Y=0) with rsp_err=1. It is not dropped.

## Timing
- Reset values: all alu_* = 0; all rsp_* = 0; rsp_valid = 0; busy = 0; done_cnt0/1 = 0; both reqN_ready = 0 during the reset cycle; pointer favours req0.
- Latency: acceptance at edge T, EXEC during cycle T+1, rsp_valid high from edge T+2.
- With rsp_ready tied high, rsp_valid is high for exactly one cycle.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP. The next acceptance is possible on the cycle after the RESP handshake.
- A request arriving while busy is stalled with ready=0. The requester holds valid and payload until it sees ready.
- rsp_ready asserted outside RESP has no effect.
- rst asserted in any state returns the block to IDLE on the next edge with reset values applied. An in-flight response is discarded and its counter is not incremented.

## Structure
- Package `alu_sched_pkg` holds:
  - the opcode constants: OP_XNOR=0, OP_ADD=1, OP_SUB=2, OP_RRA=3, OP_RLA=4, OP_RRB=5, OP_RLB=6, OP_RSVD=7;
  - the state enum {IDLE, EXEC, RESP};
  - the rotate-select constants (00 = rotate by 1, 01 = rotate by 2, 10 = rotate by 3, 11 = rotate by 0).
- Sub-module `rr_arb2`: a two-input round-robin arbiter (req[1:0], accept, gnt[1:0], with the pointer register inside).
- The ALU itself is instantiated outside this block, at the parent level.

## Test plan
- **Add:** req0 op=001, A=1100, B=0011 -> rsp_valid two cycles after acceptance; rsp_y=1111, rsp_y2=1, rsp_cout=0, rsp_id=0, done_cnt0=1.
- **Contention:** req0 and req1 both valid from reset with op=000 -> req0 granted first, then req1. A further pair of requests is granted req0 then req1 again, alternating on each acceptance.
- **Backpressure:** rsp_ready=0 for 5 cycles on op=011, rot=00, A=1100 -> rsp_y stays 0110 with rsp_valid held. No new request is accepted until rsp_ready=1.
- **Subtract with borrow:** op=010, A=0011, B=1100 -> rsp_y=0111, rsp_bout=1, rsp_y2=1.
- **Reserved opcode:** op=111 -> rsp_y=0000, rsp_err=1.
- **Counter wrap:** 256 completions on req1 -> done_cnt1 returns to 0.
- **Reset during RESP:** rst for 1 cycle -> rsp_valid=0 and busy=0 on the next edge, done_cnt unchanged, pointer favours req0.
